fpu_mult_iter_fmac: RTL

FPU_MULT_ITER_FMAC -- requirements
Module: fpu_mult_iter_fmac

---
 rtl/fpu_defs_fmac.sv | 15 +
 rtl/fpu_mult_iter_fmac.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fpu_defs_fmac.sv
// Shared FMAC definitions: default float format and the multiplier FSM encoding.
// Both the iterative multiplier and the downstream normaliser import this package.
package fpu_defs_fmac;

  localparam int C_MANT = 23;
  localparam int C_EXP  = 8;
  localparam int C_BIAS = 127;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_mult_iter_fmac.sv
// Iterative radix-4 mantissa multiplier for the FMAC path: two multiplier bits
// per cycle, LSB first, with exponent sum and product sign computed at start.
module fpu_mult_iter_fmac
  import fpu_defs_fmac::state_e, fpu_defs_fmac::S_IDLE, fpu_defs_fmac::S_MULT, fpu_defs_fmac::S_DONE;
#(
  parameter int C_MANT = fpu_defs_fmac::C_MANT,
  parameter int C_EXP  = fpu_defs_fmac::C_EXP,
  parameter int C_BIAS = fpu_defs_fmac::C_BIAS
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Start_SI,
  input  logic                  Flush_SI,
  input  logic [C_MANT:0]       Mant_b_DI,
  input  logic [C_MANT:0]       Mant_c_DI,
  input  logic [C_EXP-1:0]      Exp_b_DI,
  input  logic [C_EXP-1:0]      Exp_c_DI,
  input  logic                  Sign_b_DI,
  input  logic                  Sign_c_DI,
  input  logic                  Ready_SI,
  output logic [2*C_MANT+1:0]   Mant_prod_DO,
  output logic [C_EXP+1:0]      Exp_prod_DO,
  output logic                  Sign_prod_DO,
  output logic                  Valid_SO,
  output logic                  Busy_SO
);

  localparam int C_ITER   = (C_MANT + 2) / 2;
  localparam int C_CNT_W  = $clog2(C_ITER + 1);
  localparam int C_PROD_W = 2 * C_MANT + 2;
  localparam int C_PP_W   = C_MANT + 3;
  localparam int C_DIG_W  = 2 * C_ITER;

  localparam logic [C_CNT_W-1:0] C_LAST   = C_CNT_W'(C_ITER);
  localparam logic [C_EXP+1:0]   C_BIAS_V = (C_EXP + 2)'(C_BIAS);

  state_e               r_state;
  state_e               w_nextState;

  logic [C_MANT:0]      r_mb;
  logic [C_PP_W-1:0]    r_mb3;
  logic [C_DIG_W-1:0]   r_mc;
  logic [C_PROD_W-1:0]  r_acc;
  logic [C_EXP+1:0]     r_exp;
  logic                 r_sign;
  logic [C_CNT_W-1:0]   r_cnt;

  logic [C_EXP+1:0]     w_expSum;
  logic [C_PP_W-1:0]    w_mb3;
  logic                 w_zero;
  logic [C_PP_W-1:0]    w_pp;
  logic [C_PROD_W-1:0]  w_addend;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush wins over everything; DONE never accepts a new start on its way out.
  always_comb begin
    w_nextState = r_state;
    if (Flush_SI) begin
      w_nextState = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (Start_SI) w_nextState = S_MULT;
        S_MULT:  if (r_cnt == C_LAST) w_nextState = S_DONE;
        S_DONE:  if (Ready_SI) w_nextState = S_IDLE;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  always_comb begin
    Valid_SO = (r_state == S_DONE);
    Busy_SO  = (r_state != S_IDLE);
  end

  assign Mant_prod_DO = r_acc;
  assign Exp_prod_DO  = r_exp;
  assign Sign_prod_DO = r_sign;

  // Exponent is kept two bits wider so both overflow and underflow stay visible.
  assign w_expSum = {2'b00, Exp_b_DI} + {2'b00, Exp_c_DI} - C_BIAS_V;
  assign w_mb3    = C_PP_W'(Mant_b_DI) + (C_PP_W'(Mant_b_DI) << 1);
  assign w_zero   = (r_cnt == '0) && ((r_mb == '0) || (r_mc == '0));

  always_comb begin
    w_pp = '0;
    unique case (r_mc[1:0])
      2'd0: w_pp = '0;
      2'd1: w_pp = C_PP_W'(r_mb);
      2'd2: w_pp = C_PP_W'(r_mb) << 1;
      2'd3: w_pp = r_mb3;
      default: w_pp = '0;
    endcase
  end

  assign w_addend = C_PROD_W'(w_pp) << {r_cnt, 1'b0};

  // The counter stops at C_LAST; a zero operand jumps it there so the product stays 0.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_mb   <= '0;
      r_mb3  <= '0;
      r_mc   <= '0;
      r_acc  <= '0;
      r_exp  <= '0;
      r_sign <= 1'b0;
      r_cnt  <= '0;
    end else if (Flush_SI) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start_SI) begin
            r_mb   <= Mant_b_DI;
            r_mb3  <= w_mb3;
            r_mc   <= C_DIG_W'(Mant_c_DI);
            r_exp  <= w_expSum;
            r_sign <= Sign_b_DI ^ Sign_c_DI;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        S_MULT: begin
          if (r_cnt < C_LAST) begin
            if (w_zero) begin
              r_cnt <= C_LAST;
            end else begin
              r_acc <= r_acc + w_addend;
              r_mc  <= r_mc >> 2;
              r_cnt <= r_cnt + C_CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
